// File: rtl/nibble_packer_if.sv
// Bundles the nibble stream input and the word valid/ready output of nibble_packer.
// The slave modport is the packer's view; master is the view of whoever drives it.
interface nibble_packer_if #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]            nibble_in;
    logic                  nibble_valid;
    logic                  flush;
    logic [WORD_WIDTH-1:0] word_out;
    logic                  word_valid;
    logic                  word_ready;
    logic [CNT_W-1:0]      fifo_count;
    logic                  overflow;

    modport master (
        output nibble_in, nibble_valid, flush, word_ready,
        input  word_out, word_valid, fifo_count, overflow
    );

    modport slave (
        input  nibble_in, nibble_valid, flush, word_ready,
        output word_out, word_valid, fifo_count, overflow
    );
endinterface

// File: rtl/nibble_packer.sv
// Packs a never-stalled nibble stream MSB-first into words and queues them in a
// small show-ahead FIFO; words that find the FIFO full are dropped and flagged.
module nibble_packer #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    nibble_packer_if.slave bus
);
    localparam int N   = WORD_WIDTH / 4;
    localparam int NCW = $clog2(N + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    logic [NCW-1:0]        nib_cnt_reg, nib_cnt_next;
    logic [WORD_WIDTH-1:0] asm_reg, asm_next;
    logic [WORD_WIDTH-1:0] asm_shift, filled, push_word;
    logic [NCW-1:0]        filled_cnt;
    logic                  complete, flush_act, push, pop, full, do_write;
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [WORD_WIDTH-1:0] out_reg, out_next;
    logic                  overflow_reg, overflow_next;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

    always_comb begin
        asm_shift  = (asm_reg << 4) | WORD_WIDTH'(bus.nibble_in);
        complete   = bus.nibble_valid && (nib_cnt_reg == NCW'(N - 1));
        flush_act  = bus.flush && ((nib_cnt_reg != '0) || bus.nibble_valid);
        push       = complete || flush_act;

        // A same-cycle nibble joins the word before the left-alignment shift.
        filled     = bus.nibble_valid ? asm_shift : asm_reg;
        filled_cnt = nib_cnt_reg + NCW'(bus.nibble_valid);
        push_word  = filled << (4 * (N - int'(filled_cnt)));

        nib_cnt_next = nib_cnt_reg;
        asm_next     = asm_reg;
        if (push) begin
            nib_cnt_next = '0;
            asm_next     = '0;
        end else if (bus.nibble_valid) begin
            nib_cnt_next = nib_cnt_reg + NCW'(1);
            asm_next     = asm_shift;
        end
    end

    always_comb begin
        pop           = (count_reg != '0) && bus.word_ready;
        full          = (count_reg == CW'(FIFO_DEPTH));
        do_write      = push && (!full || pop);
        wr_ptr_next   = wr_ptr_reg + PW'(do_write);
        rd_ptr_next   = rd_ptr_reg + PW'(pop);
        count_next    = count_reg + CW'(do_write) - CW'(pop);
        overflow_next = overflow_reg | (push && full && !pop);

        // Output register tracks the head after this edge; the head is the
        // incoming word when it lands in the slot the read pointer moves to.
        out_next = out_reg;
        if (count_next != '0) begin
            if (do_write && (rd_ptr_next == wr_ptr_reg))
                out_next = push_word;
            else
                out_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_cnt_reg  <= '0;
            asm_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            out_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            nib_cnt_reg  <= nib_cnt_next;
            asm_reg      <= asm_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            out_reg      <= out_next;
            overflow_reg <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr_reg] <= push_word;
    end

    assign bus.word_out   = out_reg;
    assign bus.word_valid = (count_reg != '0);
    assign bus.fifo_count = count_reg;
    assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: a vector table for the basic packing
// case, a queue-based reference model for every cycle, and directed corner cases.
module tb_nibble_packer;
    localparam int WW    = 32;
    localparam int DEPTH = 4;
    localparam int N     = WW / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_packer_if #(.WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) bus ();

    nibble_packer #(.WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        v;
        logic [3:0]  nib;
        logic        fl;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        tbl [10];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];
    logic [3:0]  nib_q [$];
    logic        m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        nib_q.delete();
        m_ovf = 1'b0;
    endtask

    // Drives one cycle (called at posedge+1), advances the model, checks at posedge+1.
    task automatic step(input logic v, input logic [3:0] nib, input logic fl, input logic rdy);
        logic [31:0] w;
        bit          pop, full, push;
        bus.nibble_valid = v;
        bus.nibble_in    = nib;
        bus.flush        = fl;
        bus.word_ready   = rdy;
        pop  = rdy && (sb_q.size() != 0);
        if (pop) check("pop_word", bus.word_out, sb_q[0]);
        full = (sb_q.size() == DEPTH);
        if (v) nib_q.push_back(nib);
        push = (nib_q.size() == N) || (fl && nib_q.size() != 0);
        w = '0;
        if (push) begin
            for (int i = 0; i < nib_q.size(); i++) w[31-4*i -: 4] = nib_q[i];
            nib_q.delete();
        end
        if (pop) void'(sb_q.pop_front());
        if (push) begin
            if (!full || pop) sb_q.push_back(w);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        $display("cyc v=%0d nib=%h fl=%0d rdy=%0d -> valid=%0d count=%0d word=%08h ovf=%0d",
                 v, nib, fl, rdy, bus.word_valid, bus.fifo_count, bus.word_out, bus.overflow);
        check("word_valid", 32'(bus.word_valid), 32'(sb_q.size() != 0));
        check("fifo_count", 32'(bus.fifo_count), 32'(sb_q.size()));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (sb_q.size() != 0) check("head_word", bus.word_out, sb_q[0]);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.nibble_valid = 1'b0;
        bus.nibble_in    = 4'h0;
        bus.flush        = 1'b0;
        bus.word_ready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] j;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 4'(i + 1), 1'b0, 1'b1, (i == 7), 3'((i == 7) ? 1 : 0),
                       (i == 7) ? 32'h12345678 : 32'h0};
        tbl[8] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h12345678};
        tbl[9] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h12345678};

        do_reset();
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_word", bus.word_out, 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);

        // Basic packing, table-driven
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].nib, tbl[i].fl, tbl[i].rdy);
            check("tbl_valid", 32'(bus.word_valid), 32'(tbl[i].exp_valid));
            check("tbl_count", 32'(bus.fifo_count), 32'(tbl[i].exp_count));
            check("tbl_word", bus.word_out, tbl[i].exp_word);
        end

        // Partial flush, fresh word afterwards, flush when nothing pending
        step(1'b1, 4'hA, 1'b0, 1'b1);
        step(1'b1, 4'hB, 1'b0, 1'b1);
        step(1'b1, 4'hC, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        check("flush_word", bus.word_out, 32'hABC00000);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'(9 - i), 1'b0, 1'b1);
        check("fresh_word", bus.word_out, 32'h98765432);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1);
        check("empty_flush", 32'(bus.fifo_count), 32'd0);

        // Flush with a nibble in the same cycle
        step(1'b1, 4'hD, 1'b0, 1'b1);
        step(1'b1, 4'hE, 1'b0, 1'b1);
        step(1'b1, 4'hF, 1'b1, 1'b1);
        check("flush_with_nib", bus.word_out, 32'hDEF00000);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // Flush coinciding with completion pushes exactly one word
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        check("pre_flush_cnt", 32'(bus.fifo_count), 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 6), (i == 7), 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        check("complete_flush_cnt", 32'(bus.fifo_count), 32'd2);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // Overflow: five words into a four-entry FIFO
        do_reset();
        for (int w = 0; w < 5; w++)
            for (int k = 0; k < 8; k++) step(1'b1, 4'(w), 1'b0, 1'b0);
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int w = 0; w < 4; w++) begin
            j = 4'(w);
            check("drain_word", bus.word_out, {8{j}});
            step(1'b0, 4'h0, 1'b0, 1'b1);
        end
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("drain_count", 32'(bus.fifo_count), 32'd0);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom_range(15)), 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b0, 1'b1);
        check("full_pp_count", 32'(bus.fifo_count), 32'd4);
        check("full_pp_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b1);

        // Gapped valid: invalid cycles carry junk nibbles
        for (int i = 0; i < 16; i++)
            step((i % 2) == 0, ((i % 2) == 0) ? 4'(2 * (i / 2) + 1) : 4'($urandom_range(15)),
                 1'b0, 1'b0);
        check("gap_word", bus.word_out, 32'h13579BDF);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with two words and a partial queued
        for (int i = 0; i < 21; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.fifo_count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.word_valid), 32'd0);
        check("arst_count", 32'(bus.fifo_count), 32'd0);
        check("arst_word", bus.word_out, 32'd0);
        check("arst_ovf", 32'(bus.overflow), 32'd0);
        model_reset();
        bus.nibble_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 4'(15 - i), 1'b0, 1'b0);
        check("post_rst_word", bus.word_out, 32'hFEDCBA98);
        check("post_rst_count", 32'(bus.fifo_count), 32'd1);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
